// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage MIPS-subset pipeline: encodings,
// ALU operation enum, pipeline-register layouts and their bubble values.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      alu_op_e     alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] alu_res;
      logic [31:0] store_data;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  dest;
      logic        reg_write;
   } mem_wb_t;

   // An all-zero word decodes as sll $0,$0,0, which this subset treats as NOP.
   localparam if_id_t  IF_ID_NOP  = '0;
   localparam id_ex_t  ID_EX_NOP  = '0;
   localparam ex_mem_t EX_MEM_NOP = '0;
   localparam mem_wb_t MEM_WB_NOP = '0;

   function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
      alu_eval = a + b;
      case (op)
         ALU_ADD: alu_eval = a + b;
         ALU_SUB: alu_eval = a - b;
         ALU_AND: alu_eval = a & b;
         ALU_OR:  alu_eval = a | b;
         ALU_SLT: alu_eval = {31'd0, ($signed(a) < $signed(b))};
         default: alu_eval = a + b;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_processor_regfile.sv
// 2-read / 1-write register file; $0 is hard zero and a same-cycle write
// is bypassed to the readers so ID sees the value WB is retiring.
module pipeline_processor_regfile #(
   parameter int NREGS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  i_raddr_a,
   input  logic [4:0]  i_raddr_b,
   output logic [31:0] o_rdata_a,
   output logic [31:0] o_rdata_b,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata
);

   logic [31:0] r_regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata_a = '0;
      o_rdata_b = '0;
      if (i_raddr_a != 5'd0)
         o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
      if (i_raddr_b != 5'd0)
         o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];
   end

endmodule

// File: rtl/pipeline_processor.sv
// Five-stage in-order MIPS-subset CPU with full forwarding, load-use stall,
// EX-resolved beq and ID-resolved j. Memory lives outside this block.
module pipeline_processor
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] inst_addr,
   input  logic [31:0] instr,
   output logic [31:0] data_addr,
   output logic [31:0] data_out,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] data_in
);

   logic [31:0] r_pc;
   if_id_t      r_if_id;
   id_ex_t      r_id_ex;
   ex_mem_t     r_ex_mem;
   mem_wb_t     r_mem_wb;

   logic [31:0] w_pc4;
   logic [5:0]  w_op, w_funct;
   logic [4:0]  w_rs, w_rt, w_rd;
   logic [31:0] w_rs_val, w_rt_val;
   logic [31:0] w_jump_target;
   logic        w_jump, w_load_use;
   id_ex_t      w_dec;
   logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_br_target;
   logic        w_br_taken;
   ex_mem_t     w_ex_mem;
   mem_wb_t     w_mem_wb;

   assign w_pc4     = r_pc + 32'd4;
   assign inst_addr = r_pc;

   assign w_op          = r_if_id.instr[31:26];
   assign w_rs          = r_if_id.instr[25:21];
   assign w_rt          = r_if_id.instr[20:16];
   assign w_rd          = r_if_id.instr[15:11];
   assign w_funct       = r_if_id.instr[5:0];
   assign w_jump        = (w_op == OP_J);
   assign w_jump_target = {r_if_id.pc4[31:28], r_if_id.instr[25:0], 2'b00};

   pipeline_processor_regfile #(.NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_raddr_a (w_rs),
      .i_raddr_b (w_rt),
      .o_rdata_a (w_rs_val),
      .o_rdata_b (w_rt_val),
      .i_we      (r_mem_wb.reg_write),
      .i_waddr   (r_mem_wb.dest),
      .i_wdata   (r_mem_wb.wb_data)
   );

   always_comb begin
      w_dec        = ID_EX_NOP;
      w_dec.pc4    = r_if_id.pc4;
      w_dec.rs_val = w_rs_val;
      w_dec.rt_val = w_rt_val;
      w_dec.imm    = {{16{r_if_id.instr[15]}}, r_if_id.instr[15:0]};
      w_dec.rs     = w_rs;
      w_dec.rt     = w_rt;
      case (w_op)
         OP_RTYPE: begin
            w_dec.dest = w_rd;
            case (w_funct)
               FN_ADD: begin w_dec.alu_op = ALU_ADD; w_dec.reg_write = 1'b1; end
               FN_SUB: begin w_dec.alu_op = ALU_SUB; w_dec.reg_write = 1'b1; end
               FN_AND: begin w_dec.alu_op = ALU_AND; w_dec.reg_write = 1'b1; end
               FN_OR:  begin w_dec.alu_op = ALU_OR;  w_dec.reg_write = 1'b1; end
               FN_SLT: begin w_dec.alu_op = ALU_SLT; w_dec.reg_write = 1'b1; end
               default: ;
            endcase
         end
         OP_ADDI: begin
            w_dec.dest = w_rt; w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1;
         end
         OP_LW: begin
            w_dec.dest = w_rt; w_dec.alu_src = 1'b1; w_dec.reg_write = 1'b1;
            w_dec.mem_read = 1'b1;
         end
         OP_SW:  begin w_dec.alu_src = 1'b1; w_dec.mem_write = 1'b1; end
         OP_BEQ: w_dec.branch = 1'b1;
         default: ;
      endcase
   end

   // A load in EX cannot feed ID's consumer until it reaches MEM/WB.
   assign w_load_use = r_id_ex.mem_read &&
                       ((r_id_ex.rt == w_rs) || (r_id_ex.rt == w_rt));

   always_comb begin
      w_fwd_a = r_id_ex.rs_val;
      w_fwd_b = r_id_ex.rt_val;
      if (r_ex_mem.reg_write && (r_ex_mem.dest != 5'd0) && (r_ex_mem.dest == r_id_ex.rs))
         w_fwd_a = r_ex_mem.alu_res;
      else if (r_mem_wb.reg_write && (r_mem_wb.dest != 5'd0) && (r_mem_wb.dest == r_id_ex.rs))
         w_fwd_a = r_mem_wb.wb_data;
      if (r_ex_mem.reg_write && (r_ex_mem.dest != 5'd0) && (r_ex_mem.dest == r_id_ex.rt))
         w_fwd_b = r_ex_mem.alu_res;
      else if (r_mem_wb.reg_write && (r_mem_wb.dest != 5'd0) && (r_mem_wb.dest == r_id_ex.rt))
         w_fwd_b = r_mem_wb.wb_data;
   end

   assign w_alu_b     = r_id_ex.alu_src ? r_id_ex.imm : w_fwd_b;
   assign w_br_taken  = r_id_ex.branch && (w_fwd_a == w_fwd_b);
   assign w_br_target = r_id_ex.pc4 + {r_id_ex.imm[29:0], 2'b00};

   always_comb begin
      w_ex_mem            = EX_MEM_NOP;
      w_ex_mem.alu_res    = alu_eval(r_id_ex.alu_op, w_fwd_a, w_alu_b);
      w_ex_mem.store_data = w_fwd_b;
      w_ex_mem.dest       = r_id_ex.dest;
      w_ex_mem.reg_write  = r_id_ex.reg_write;
      w_ex_mem.mem_read   = r_id_ex.mem_read;
      w_ex_mem.mem_write  = r_id_ex.mem_write;
   end

   always_comb begin
      w_mem_wb           = MEM_WB_NOP;
      w_mem_wb.wb_data   = r_ex_mem.mem_read ? data_in : r_ex_mem.alu_res;
      w_mem_wb.dest      = r_ex_mem.dest;
      w_mem_wb.reg_write = r_ex_mem.reg_write;
   end

   assign data_addr = r_ex_mem.alu_res;
   assign data_out  = r_ex_mem.store_data;
   assign mem_read  = r_ex_mem.mem_read;
   assign mem_write = r_ex_mem.mem_write;

   // Front-end priority: branch flush, then jump, then load-use stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_PC;
         r_if_id  <= IF_ID_NOP;
         r_id_ex  <= ID_EX_NOP;
         r_ex_mem <= EX_MEM_NOP;
         r_mem_wb <= MEM_WB_NOP;
      end else begin
         r_ex_mem <= w_ex_mem;
         r_mem_wb <= w_mem_wb;
         if (w_br_taken) begin
            r_pc    <= w_br_target;
            r_if_id <= IF_ID_NOP;
            r_id_ex <= ID_EX_NOP;
         end else if (w_jump) begin
            r_pc    <= w_jump_target;
            r_if_id <= IF_ID_NOP;
            r_id_ex <= ID_EX_NOP;
         end else if (w_load_use) begin
            r_id_ex <= ID_EX_NOP;
         end else begin
            r_pc          <= w_pc4;
            r_if_id.pc4   <= w_pc4;
            r_if_id.instr <= instr;
            r_id_ex       <= w_dec;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_processor.sv
// Directed bench for pipeline_processor: small programs run against a
// combinational memory model, stores compared against an expected queue.
module tb_pipeline_processor;

   logic        clk;
   logic        reset;
   logic [31:0] inst_addr;
   logic [31:0] instr;
   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] data_in;

   logic [31:0] imem [64];
   logic [31:0] dmem [64];

   logic [63:0] exp_q [$];
   logic [63:0] obs_q [$];

   int checks;
   int errors;
   int holds;
   int overlap;

   pipeline_processor processor (
      .clk       (clk),
      .reset     (reset),
      .inst_addr (inst_addr),
      .instr     (instr),
      .data_addr (data_addr),
      .data_out  (data_out),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .data_in   (data_in)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   assign instr   = imem[inst_addr[7:2]];
   assign data_in = dmem[data_addr[7:2]];

   // Data memory is re-seeded on every reset so each program starts clean.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) dmem[i] <= 32'hBAD0_0000 | i;
         dmem[4] <= 32'd7;
      end else if (mem_write) begin
         dmem[data_addr[7:2]] <= data_out;
      end
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'h00, funct};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_imem;
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst inst_addr", inst_addr, 32'h0);
      check("rst mem_read", {31'd0, mem_read}, 32'h0);
      check("rst mem_write", {31'd0, mem_write}, 32'h0);
      obs_q.delete();
      exp_q.delete();
      holds = 0;
      reset = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      logic [31:0] prev;
      prev = inst_addr;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (inst_addr == prev) holds++;
         prev = inst_addr;
         if (mem_write) obs_q.push_back({data_addr, data_out});
         if (mem_read && mem_write) overlap++;
      end
   endtask

   task automatic check_stores(input string tag);
      logic [63:0] o;
      logic [63:0] e;
      check({tag, " store count"}, obs_q.size(), exp_q.size());
      for (int i = 0; (i < exp_q.size()) && (i < obs_q.size()); i++) begin
         o = obs_q[i];
         e = exp_q[i];
         check({tag, " data_addr"}, o[63:32], e[63:32]);
         check({tag, " data_out"}, o[31:0], e[31:0]);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      holds   = 0;
      overlap = 0;
      reset   = 1'b1;

      // Reset and sequential fetch
      clear_imem();
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("seq inst_addr", inst_addr, 32'(4 * k));
      end

      // Forwarding: EX/MEM and MEM/WB paths plus store data
      clear_imem();
      imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      imem[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd3);
      imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      imem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
      do_reset();
      exp_q.push_back({32'd0, 32'd13});
      run_cycles(12);
      check_stores("fwd");
      check("fwd holds", holds, 0);

      // Load-use: one bubble, then MEM/WB forward of load data
      clear_imem();
      imem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'd16);
      imem[1] = enc_r(5'd4, 5'd4, 5'd5, 6'h20);
      imem[2] = enc_i(6'h2B, 5'd0, 5'd5, 16'd4);
      do_reset();
      exp_q.push_back({32'd4, 32'd14});
      run_cycles(12);
      check_stores("ldu");
      check("ldu holds", holds, 1);

      // Taken branch skips two writers of $6
      clear_imem();
      imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
      imem[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
      imem[2] = enc_i(6'h08, 5'd6, 5'd6, 16'd2);
      imem[3] = enc_i(6'h2B, 5'd0, 5'd6, 16'd12);
      do_reset();
      exp_q.push_back({32'd12, 32'd0});
      run_cycles(12);
      check_stores("beq");

      // Jump flushes its successor; $0 stays zero
      clear_imem();
      imem[0]  = {6'h02, 26'h10};
      imem[1]  = enc_i(6'h2B, 5'd0, 5'd0, 16'd20);
      imem[16] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      imem[17] = enc_i(6'h2B, 5'd0, 5'd0, 16'd8);
      do_reset();
      exp_q.push_back({32'd8, 32'd0});
      run_cycles(14);
      check_stores("jmp");

      // Reset while a store sits in EX
      clear_imem();
      imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
      imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd24);
      do_reset();
      run_cycles(3);
      reset = 1'b1;
      run_cycles(2);
      check_stores("rst mid");
      check("rst mid inst_addr", inst_addr, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("rst mid refetch", inst_addr, 32'h4);

      check("mem port overlap", overlap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
